ps2_host_tx: RTL and testbench

// - Host-to-device PS/2 transmitter: sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset) to the keyboard.
// - Sits beside the PS/2 keyboard receiver on the same open-drain clk/data pair; busy gates that receiver while a send is in flight.
// - Runs the inhibit / request-to-send sequence, shifts out data + odd parity + stop on device-generated clocks, and checks the device ACK.

---
 rtl/ps2_pkg.sv | 58 +++++
 rtl/ps2_sync_edge.sv | 25 ++
 rtl/ps2_host_tx.sv | 194 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, frame payload,
// command/response byte constants and small frame helpers.
package ps2_pkg;

  localparam int unsigned PS2_DATA_W = 8;
  localparam int unsigned BIT_CNT_W  = 4;

  localparam logic [PS2_DATA_W-1:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [PS2_DATA_W-1:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [PS2_DATA_W-1:0] PS2_RSP_ACK     = 8'hFA;
  localparam logic [PS2_DATA_W-1:0] PS2_EXT         = 8'hE0;
  localparam logic [PS2_DATA_W-1:0] PS2_BRK         = 8'hF0;

  // Device falling-edge ordinals that mark the end of each frame section
  localparam logic [BIT_CNT_W-1:0] FE_LAST_DATA = 4'd8;
  localparam logic [BIT_CNT_W-1:0] FE_PARITY    = 4'd9;
  localparam logic [BIT_CNT_W-1:0] FE_STOP      = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } tx_state_e;

  typedef struct packed {
    logic [PS2_DATA_W-1:0] data;
    logic                  parity;
  } tx_frame_t;

  function automatic logic odd_parity(input logic [PS2_DATA_W-1:0] d);
    return ~^d;
  endfunction

  // 1 = pull data low for the frame bit that follows falling edge n (0 = start bit)
  function automatic logic frame_bit_low(input tx_frame_t f, input logic [BIT_CNT_W-1:0] n);
    logic low;
    low = 1'b0;
    if (n == '0) begin
      low = 1'b1;
    end else if (n <= FE_LAST_DATA) begin
      low = ~f.data[3'(n - 4'd1)];
    end else if (n == FE_PARITY) begin
      low = ~f.parity;
    end
    return low;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Three-flop synchronizer for an asynchronous PS/2 pad, with a one-cycle
// falling-edge pulse on the synchronized level.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  output logic level_o,
  output logic fe_c
);

  logic [2:0] sync_q;

  // Reset to the idle (released) bus level so no edge is seen out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], pad_i};
    end
  end

  assign level_o = sync_q[1];
  assign fe_c    = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit and request-to-send, frame shift on
// device clocks, ACK check, idle-bus wait, all guarded by one shared counter.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned START_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       done,
  output logic       err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CNT_MAX = max3(INHIBIT_CYCLES, START_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  tx_frame_t            frame_q, frame_d;

  logic tx_ready_q, tx_ready_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic busy_q, busy_d;
  logic clk_oe_q, clk_oe_d;
  logic data_oe_q, data_oe_d;

  logic clk_lvl, clk_fe;
  logic data_lvl, data_fe_unused;
  logic timeout_c, ack_fail_c;

  ps2_sync_edge u_sync_clk (
    .clk     (clk),
    .rst_n   (rst_n),
    .pad_i   (ps2_clk_in),
    .level_o (clk_lvl),
    .fe_c    (clk_fe)
  );

  ps2_sync_edge u_sync_data (
    .clk     (clk),
    .rst_n   (rst_n),
    .pad_i   (ps2_data_in),
    .level_o (data_lvl),
    .fe_c    (data_fe_unused)
  );

  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus counter/frame datapath; the counter restarts on every state change
  always_comb begin : next_state
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    timeout_c  = 1'b0;
    ack_fail_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          frame_d.data   = tx_data;
          frame_d.parity = odd_parity(tx_data);
          bit_cnt_d      = '0;
          state_d        = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        cnt_d = clk_fe ? '0 : cnt_q + 1'b1;
        if (clk_fe) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == FE_STOP - 4'd1) begin
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        cnt_d = clk_fe ? '0 : cnt_q + 1'b1;
        if (clk_fe) begin
          bit_cnt_d  = bit_cnt_q + 1'b1;
          ack_fail_c = data_lvl;
          state_d    = data_lvl ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = cnt_q + 1'b1;
        if (clk_lvl && data_lvl) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Device went silent: abandon the transfer and release the bus
    if ((state_q == ST_SHIFT || state_q == ST_ACK || state_q == ST_WAIT_IDLE) &&
        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      timeout_c  = 1'b1;
      ack_fail_c = 1'b0;
      state_d    = ST_IDLE;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Outputs are decoded from the next state so each register lines up with its state
  always_comb begin : output_dec
    clk_oe_d   = 1'b0;
    data_oe_d  = 1'b0;
    tx_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_q == ST_WAIT_IDLE) && (state_d == ST_IDLE) && !timeout_c;
    err_d      = timeout_c || ack_fail_c;

    unique case (state_d)
      ST_INHIBIT: begin
        clk_oe_d = 1'b1;
      end
      ST_START: begin
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b1;
      end
      ST_SHIFT: begin
        data_oe_d = frame_bit_low(frame_q, bit_cnt_d);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin : data_reg
    if (!rst_n) begin
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      frame_q    <= '0;
      tx_ready_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      tx_ready_q <= tx_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign tx_ready    = tx_ready_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a clocking device model, table of
// command bytes plus hand-written hold-valid and mid-transfer reset sequences.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 100;
  localparam int STC  = 2;
  localparam int TMO  = 5000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, done, err, busy, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_line = ~ps2_data_oe & dev_data;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_CYCLES   (STC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  // kind: 0 = ACKed (done), 1 = no ACK (err), 2 = device silent (timeout err)
  typedef struct {
    logic [7:0] data;
    int         nclk;
    bit         ack;
    logic       parity;
    int         kind;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       parity;
    int         kind;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[6];
  int          n_tests = 0;
  int          n_fail = 0;
  int          done_total = 0;
  int          err_total = 0;
  logic [10:0] last_cap = '1;
  logic        done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: each done/err pulse retires the oldest accepted byte
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (done || err)) begin
      check("done_err_exclusive", 32'(done & err), 32'd0);
      if (done) begin
        check("done_single_cycle", 32'(done_prev), 32'd0);
        done_total++;
      end
      if (err) err_total++;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got done=%0d err=%0d expected no pulse", done, err);
      end else begin
        e = sb_q.pop_front();
        check("outcome_done", 32'(done), 32'(e.kind == 0));
        check("outcome_err", 32'(err), 32'(e.kind != 0));
        if (e.kind != 2) begin
          check("dev_start_bit", 32'(last_cap[0]), 32'd0);
          check("dev_byte", 32'(last_cap[8:1]), 32'(e.data));
          check("dev_parity", 32'(last_cap[9]), 32'(e.parity));
          check("dev_stop_bit", 32'(last_cap[10]), 32'd1);
        end
      end
    end
    done_prev <= rst_n & done;
  end

  // Device model: waits for request-to-send, then clocks nclk bits, sampling on rising edges
  task automatic device_run(input int nclk, input bit ack, output int inh, output int st,
                            output bit req);
    logic [10:0] cap;
    inh = 0;
    st  = 0;
    req = 1'b0;
    cap = '1;
    for (int i = 0; i < 1000 && !req; i++) begin
      @(negedge clk);
      if (ps2_clk_oe && !ps2_data_oe) inh++;
      else if (ps2_clk_oe && ps2_data_oe) st++;
      else if (!ps2_clk_oe && ps2_data_oe && inh > 0) req = 1'b1;
    end
    if (req && nclk > 0) begin
      repeat (HALF) @(negedge clk);
      cap[0] = ps2_data_line;
      for (int k = 1; k <= nclk && k <= 10; k++) begin
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        cap[k] = ps2_data_line;
        repeat (HALF) @(negedge clk);
      end
      if (nclk >= 11) begin
        last_cap = cap;
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (HALF / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
      end
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!tx_ready && k < 10000) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_send", 32'(tx_ready), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(tx_ready), 32'd1);
    check({tag, "_clk_oe"}, 32'(ps2_clk_oe), 32'd0);
    check({tag, "_data_oe"}, 32'(ps2_data_oe), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int inh, st, k, d0, e0;
    bit req;
    d0 = done_total;
    e0 = err_total;
    wait_ready();
    tx_data  = v.data;
    tx_valid = 1'b1;
    sb_q.push_back('{v.data, v.parity, v.kind});
    fork
      device_run(v.nclk, v.ack, inh, st, req);
      begin
        @(negedge clk);
        tx_valid = 1'b0;
        check($sformatf("v%0d_busy_after_accept", idx), 32'(busy), 32'd1);
        check($sformatf("v%0d_ready_low", idx), 32'(tx_ready), 32'd0);
      end
    join
    check($sformatf("v%0d_inhibit_cycles", idx), 32'(inh), 32'(INH));
    check($sformatf("v%0d_start_cycles", idx), 32'(st), 32'(STC));
    check($sformatf("v%0d_rts_seen", idx), 32'(req), 32'd1);
    k = 0;
    if (v.nclk == 0) begin
      while (!err && !done && k < 6000) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("v%0d_timeout_latency", idx), 32'(k), 32'(TMO));
      check($sformatf("v%0d_timeout_err", idx), 32'(err), 32'd1);
    end else begin
      while (done_total == d0 && err_total == e0 && k < 2000) begin
        @(negedge clk);
        k++;
      end
      @(negedge clk);
    end
    check_idle($sformatf("v%0d_after", idx));
    repeat (20) @(negedge clk);
    check($sformatf("v%0d_done_count", idx), 32'(done_total - d0), 32'(v.kind == 0));
    check($sformatf("v%0d_err_count", idx), 32'(err_total - e0), 32'(v.kind != 0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int inh, st, k, d0;
    bit req;

    vecs[0] = '{PS2_CMD_SET_LED, 11, 1'b1, 1'b1, 0};
    vecs[1] = '{8'h07,           11, 1'b1, 1'b0, 0};
    vecs[2] = '{8'h00,           11, 1'b1, 1'b1, 0};
    vecs[3] = '{PS2_CMD_RESET,   11, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h3C,           11, 1'b0, 1'b1, 1};
    vecs[5] = '{8'h5A,            0, 1'b0, 1'b1, 2};

    repeat (5) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // tx_valid held with new data during a send: only taken once tx_ready returns
    d0 = done_total;
    wait_ready();
    tx_data  = 8'h07;
    tx_valid = 1'b1;
    sb_q.push_back('{8'h07, 1'b0, 0});
    fork
      device_run(11, 1'b1, inh, st, req);
      begin
        @(negedge clk);
        tx_data = 8'hA5;
        sb_q.push_back('{8'hA5, 1'b1, 0});
      end
    join
    check("hold_a_inhibit", 32'(inh), 32'(INH));
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("hold_a_done", 32'(done), 32'd1);
    fork
      device_run(11, 1'b1, inh, st, req);
      begin
        @(negedge clk);
        tx_valid = 1'b0;
        check("hold_b_busy", 32'(busy), 32'd1);
      end
    join
    check("hold_b_inhibit", 32'(inh), 32'(INH));
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check_idle("hold_after");
    repeat (20) @(negedge clk);
    check("hold_done_count", 32'(done_total - d0), 32'd2);

    // Reset in the middle of the shift phase releases the bus on that edge
    wait_ready();
    tx_data  = PS2_CMD_SET_LED;
    tx_valid = 1'b1;
    sb_q.push_back('{PS2_CMD_SET_LED, 1'b1, 0});
    fork
      device_run(4, 1'b1, inh, st, req);
      begin
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    check("shift_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    sb_q.delete();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    run_vec(vecs[0], 6);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
